// File: rtl/rv3n_bht_predictor.sv
// rv3n_bht_predictor: 2-bit saturating-counter branch history table with an init sweep, registered 1-cycle prediction answers and saturating update/mispredict statistics.
// Ports: clk/rst (sync, active-low); ch2predictor_* resolved-branch reports; fetch_pdt_req_* queries; fetch_pdt_ack_* answers; predictor_ready; pdt_update_count/pdt_miss_count.
module rv3n_bht_predictor #(
  parameter int          XLEN      = 32,
  parameter int          BHT_IDX_W = 6,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ch2predictor_valid,
  input  logic [XLEN-1:0] ch2predictor_pc,
  input  logic            ch2predictor_predict,
  input  logic            ch2predictor_taken,
  input  logic            fetch_pdt_req_valid,
  input  logic [XLEN-1:0] fetch_pdt_req_pc,
  output logic            fetch_pdt_ack_valid,
  output logic            fetch_pdt_ack_taken,
  output logic            predictor_ready,
  output logic [31:0]     pdt_update_count,
  output logic [31:0]     pdt_miss_count
);
  typedef enum logic {INIT, RUN} state_e;
  state_e               state_q, state_d;
  logic [BHT_IDX_W-1:0] sweep_q, sweep_d, upd_idx, req_idx;
  logic [1:0]           tbl_q [2**BHT_IDX_W];
  logic [1:0]           cur, nxt;
  logic                 upd, ready_q, ack_valid_q, ack_taken_q, ack_taken_d;
  logic [31:0]          upd_cnt_q, miss_cnt_q;
  logic                 unused_pc;
  assign unused_pc = ^{ch2predictor_pc[XLEN-1:BHT_IDX_W+1], ch2predictor_pc[0],
                       fetch_pdt_req_pc[XLEN-1:BHT_IDX_W+1], fetch_pdt_req_pc[0]};
  // Halfword-granular index so RVC branches get their own entries.
  assign upd_idx = ch2predictor_pc[BHT_IDX_W:1];
  assign req_idx = fetch_pdt_req_pc[BHT_IDX_W:1];
  assign upd     = rst && ch2predictor_valid && state_q == RUN;
  assign cur     = tbl_q[upd_idx];
  assign nxt     = ch2predictor_taken ? cur + {1'b0, cur != 2'b11} : cur - {1'b0, cur != 2'b00};
  always_comb begin
    state_d     = (state_q == INIT && sweep_q == '1) ? RUN : state_q;
    sweep_d     = state_q == INIT ? sweep_q + 1'b1 : sweep_q;
    // A same-cycle update to the queried entry is forwarded so the answer sees it.
    ack_taken_d = fetch_pdt_req_valid && state_q == RUN &&
                  ((upd && upd_idx == req_idx) ? nxt[1] : tbl_q[req_idx][1]);
  end
  // Table has no reset of its own; the sweep after every reset rewrites it.
  always_ff @(posedge clk) begin
    if (rst && state_q == INIT) tbl_q[sweep_q] <= CNT_INIT;
    else if (upd) tbl_q[upd_idx] <= nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      ready_q     <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_taken_q <= 1'b0;
      upd_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      ready_q     <= state_q == RUN;
      ack_valid_q <= fetch_pdt_req_valid;
      ack_taken_q <= ack_taken_d;
      upd_cnt_q   <= upd_cnt_q + 32'(upd && upd_cnt_q != '1);
      miss_cnt_q  <= miss_cnt_q + 32'(upd && ch2predictor_predict != ch2predictor_taken && miss_cnt_q != '1);
    end
  end
  assign fetch_pdt_ack_valid = ack_valid_q;
  assign fetch_pdt_ack_taken = ack_taken_q;
  assign predictor_ready     = ready_q;
  assign pdt_update_count    = upd_cnt_q;
  assign pdt_miss_count      = miss_cnt_q;
endmodule

// File: tb/tb_rv3n_bht_predictor.sv
// tb_rv3n_bht_predictor: randomized and directed bench for rv3n_bht_predictor against a counter-array reference model.
module tb_rv3n_bht_predictor;
  logic        clk = 1'b0, rst = 1'b0;
  logic        uv = 1'b0, up = 1'b0, ut = 1'b0, qv = 1'b0;
  logic [31:0] upc = '0, qpc = '0;
  logic        ack_valid, ack_taken, ready;
  logic [31:0] upd_count, miss_count;
  int          n_cmp = 0, n_bad = 0;
  int          k = 0;
  int          mcnt [64];
  longint      m_upd = 0, m_miss = 0;
  bit          m_av = 0, m_at = 0, m_rdy = 0;
  rv3n_bht_predictor dut (
    .clk(clk), .rst(rst),
    .ch2predictor_valid(uv), .ch2predictor_pc(upc),
    .ch2predictor_predict(up), .ch2predictor_taken(ut),
    .fetch_pdt_req_valid(qv), .fetch_pdt_req_pc(qpc),
    .fetch_pdt_ack_valid(ack_valid), .fetch_pdt_ack_taken(ack_taken),
    .predictor_ready(ready),
    .pdt_update_count(upd_count), .pdt_miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // One clock edge with the current inputs; the model follows the behavioural rules, then every output is compared.
  task automatic step();
    int ui, qi;
    bit run;
    @(posedge clk);
    ui = int'(upc[6:1]);
    qi = int'(qpc[6:1]);
    if (!rst) begin
      k = 0; m_upd = 0; m_miss = 0; m_av = 0; m_at = 0; m_rdy = 0;
    end else begin
      run = k >= 64;
      if (!run) mcnt[k] = 1;
      else if (uv) begin
        mcnt[ui] = ut ? (mcnt[ui] == 3 ? 3 : mcnt[ui] + 1) : (mcnt[ui] == 0 ? 0 : mcnt[ui] - 1);
        if (m_upd < 64'hFFFF_FFFF) m_upd++;
        if (up != ut && m_miss < 64'hFFFF_FFFF) m_miss++;
      end
      m_av  = qv;
      m_at  = qv && run && mcnt[qi] >= 2;
      m_rdy = run;
      k++;
    end
    #1;
    check("ack_valid", {31'b0, ack_valid}, {31'b0, m_av});
    check("ack_taken", {31'b0, ack_taken}, {31'b0, m_at});
    check("ready", {31'b0, ready}, {31'b0, m_rdy});
    check("update_count", upd_count, m_upd[31:0]);
    check("miss_count", miss_count, m_miss[31:0]);
  endtask
  task automatic upd(input logic [31:0] pc, input bit t, input bit p);
    uv = 1; upc = pc; ut = t; up = p;
    step();
    uv = 0;
  endtask
  task automatic qry(input logic [31:0] pc);
    qv = 1; qpc = pc;
    step();
    qv = 0;
  endtask
  task automatic init_wait();
    for (int i = 1; i <= 65; i++) begin
      step();
      if (i == 64) check("ready_before_65", {31'b0, ready}, 32'd0);
      if (i == 65) check("ready_after_65", {31'b0, ready}, 32'd1);
    end
  endtask
  function automatic logic [31:0] rnd_pc();
    return ($urandom & ~32'h7E) | (32'($urandom_range(0, 7)) << 1);
  endfunction
  initial begin
    rst = 0;
    step(); step();
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_ack", {31'b0, ack_valid}, 32'd0);
    rst = 1;
    qry(32'h100);
    check("init_query_valid", {31'b0, ack_valid}, 32'd1);
    check("init_query_taken", {31'b0, ack_taken}, 32'd0);
    for (int i = 0; i < 3; i++) upd(32'h100, 1, 0);
    for (int i = 5; i <= 65; i++) begin
      step();
      if (i == 64) check("ready_before_65", {31'b0, ready}, 32'd0);
      if (i == 65) check("ready_after_65", {31'b0, ready}, 32'd1);
    end
    check("init_updates_dropped", upd_count, 32'd0);
    qry(32'h100);
    check("run_query_valid", {31'b0, ack_valid}, 32'd1);
    check("run_query_taken", {31'b0, ack_taken}, 32'd0);
    upd(32'h100, 1, 0); upd(32'h100, 1, 0);
    qry(32'h100); check("trained_100", {31'b0, ack_taken}, 32'd1);
    qry(32'h180); check("alias_180", {31'b0, ack_taken}, 32'd1);
    qry(32'h104); check("other_104", {31'b0, ack_taken}, 32'd0);
    for (int i = 0; i < 5; i++) upd(32'h200, 1, 1);
    upd(32'h200, 0, 1); qry(32'h200); check("sat_hi_1nt", {31'b0, ack_taken}, 32'd1);
    upd(32'h200, 0, 1); qry(32'h200); check("sat_hi_2nt", {31'b0, ack_taken}, 32'd0);
    for (int i = 0; i < 4; i++) upd(32'h200, 0, 0);
    qry(32'h200); check("sat_lo", {31'b0, ack_taken}, 32'd0);
    upd(32'h200, 1, 0); qry(32'h200); check("sat_lo_1t", {31'b0, ack_taken}, 32'd0);
    upd(32'h200, 1, 0); qry(32'h200); check("sat_lo_2t", {31'b0, ack_taken}, 32'd1);
    uv = 1; upc = 32'h104; ut = 1; up = 0; qv = 1; qpc = 32'h104;
    step();
    uv = 0; qv = 0;
    check("bypass_valid", {31'b0, ack_valid}, 32'd1);
    check("bypass_taken", {31'b0, ack_taken}, 32'd1);
    upd(32'h300, 1, 1); upd(32'h300, 1, 1);
    qry(32'h300); check("trained_300", {31'b0, ack_taken}, 32'd1);
    qv = 1; qpc = 32'h300;
    step();
    rst = 0;
    step();
    qv = 0;
    check("squash_ack", {31'b0, ack_valid}, 32'd0);
    check("squash_ready", {31'b0, ready}, 32'd0);
    check("squash_count", upd_count, 32'd0);
    rst = 1;
    init_wait();
    qry(32'h300); check("reinit_300", {31'b0, ack_taken}, 32'd0);
    for (int i = 0; i < 10; i++) upd(32'h40A + 32'(2 * i), i % 2 == 0, (i < 3) ? (i % 2 != 0) : (i % 2 == 0));
    check("stat_updates", upd_count, 32'd10);
    check("stat_misses", miss_count, 32'd3);
    for (int c = 0; c < 400; c++) begin
      rst = !(c == 200 || c == 201);
      uv  = $urandom_range(0, 1);
      upc = rnd_pc();
      ut  = $urandom_range(0, 1);
      up  = $urandom_range(0, 1);
      qv  = $urandom_range(0, 2) != 0;
      qpc = ($urandom_range(0, 2) == 0) ? upc : rnd_pc();
      step();
    end
    rst = 1; uv = 0; qv = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv3n_bht_predictor.md
# rv3n_bht_predictor

Branch history table: the receiving end of the `ch2predictor_*` channel driven by the conditional-jump execution unit. It holds 2-bit saturating counters indexed by PC and trains them from resolved-branch reports. It answers fetch-stage prediction queries with a registered, 1-cycle-latency taken/not-taken bit. After reset it clears its table with a sweep state machine and keeps saturating update and mispredict statistics.

## Interface
- `BHT_IDX_W`, 6: index width; table depth = 2^BHT_IDX_W entries.
- `CNT_INIT`, 2'b01: counter value written by the init sweep (weakly not-taken).
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset; synchronous, active-low.
- `ch2predictor_valid`  input  1  resolved-branch report valid.
- `ch2predictor_pc`  input  `XLEN`  PC of the resolved branch.
- `ch2predictor_predict`  input  1  prediction that was used for the branch.
- `ch2predictor_taken`  input  1  actual branch outcome.
- `fetch_pdt_req_valid`  input  1  prediction query valid.
- `fetch_pdt_req_pc`  input  `XLEN`  PC to predict.
- `fetch_pdt_ack_valid`  output  1  query answer valid; 1 cycle after the request.
- `fetch_pdt_ack_taken`  output  1  predicted taken.
- `predictor_ready`  output  1  table initialised; updates accepted.
- `pdt_update_count`  output  32  accepted updates, saturating.
- `pdt_miss_count`  output  32  accepted updates with predict != taken, saturating.

## Operation
- Index = pc[BHT_IDX_W:1] (halfword granular for RVC). No tags; aliasing is permitted.
- FSM states: INIT and RUN.
  - While `rst`=0: state = INIT, sweep index = 0.
  - INIT: each cycle writes CNT_INIT to entry[sweep index], then increments the index. After the write to entry 2^BHT_IDX_W−1, the next state is RUN.
  - RUN is held until the next reset.
- `predictor_ready` = registered (state == RUN).
- Update, RUN only, when `ch2predictor_valid`=1:
  - taken=1: counter = min(counter+1, 3).
  - taken=0: counter = max(counter−1, 0).
  - `pdt_update_count` +1.
  - `pdt_miss_count` +1 if predict != taken.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Updates arriving in INIT are dropped, not counted, and do not disturb the sweep.
- Query, any state: when `fetch_pdt_req_valid`=1, the next cycle drives `fetch_pdt_ack_valid`=1 and `fetch_pdt_ack_taken` = bit 1 of the counter.
  - In INIT the answer is always taken=0.
  - With no request, ack_valid=0 and ack_taken=0.
- Same-cycle bypass: if an update and a query hit the same index in the same cycle (RUN), the query answers from the post-update counter value.
- One update port and one query port; there is no backpressure on either port.

## Timing
- Reset values, after any clock edge with `rst`=0:
  - `fetch_pdt_ack_valid`=0, `fetch_pdt_ack_taken`=0.
  - `predictor_ready`=0.
  - `pdt_update_count`=0, `pdt_miss_count`=0.
  - FSM = INIT, sweep index = 0.
- Init latency: the edges E1..E(2^BHT_IDX_W) with `rst`=1 write entries 0..2^BHT_IDX_W−1. `predictor_ready`=1 after edge E(2^BHT_IDX_W)+1. With the default depth, ready goes high after the 65th edge.
- Update latency: a report at edge N is visible to a query issued at edge N+1 without bypass, and to a query at edge N with bypass.
- Query latency: request sampled at edge N → ack valid in the cycle after edge N, for exactly 1 cycle per request. Back-to-back requests give back-to-back acks.
- Statistic outputs are registered and reflect an update 1 cycle after its edge.
- Reset mid-operation:
  - The table contents are not cleared by `rst` itself; the sweep that follows re-initialises every entry.
  - An in-flight ack is squashed.
  - Both statistics clear.

## Test plan
- Release reset, default params → `predictor_ready`=0 for 65 edges, then 1. A query of pc 0x100 during INIT and a query after ready both give ack_valid=1, taken=0.
- In RUN, two taken updates at pc 0x100 → query 0x100 gives taken=1. Query 0x180 (same index 0, aliased) gives taken=1. Query 0x104 (index 2) gives taken=0.
- Saturation at pc 0x200:
  - 5 taken updates, then 1 not-taken → taken=1.
  - 1 more not-taken → taken=0.
  - 4 further not-taken → taken=0.
  - 2 taken → taken=1 only after the 2nd taken update.
- Bypass: entry at 01; same-cycle taken update and query of the same pc → next-cycle ack_valid=1, taken=1.
- Statistics:
  - 3 updates during INIT → counts stay 0.
  - Then 10 updates in RUN, 3 with predict≠taken → `pdt_update_count`=10, `pdt_miss_count`=3.
- Train pc 0x300 to 11, then hold `rst`=0 for 1 cycle mid-query → ack squashed, counts 0, ready 0. After 65 edges ready=1 and query 0x300 gives taken=0.
